// File: rtl/controle_temporizador.sv
// Countdown-timer controller for a contador_163_n: loads a start value, steps it down once every
// TICK clocks, supports pause/resume and cancel, and reports halfway and expiry to the game FSM.
module controle_temporizador #(
  parameter int N    = 6,
  parameter int TICK = 1000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         iniciar,
  input  logic         pausar,
  input  logic         cancelar,
  input  logic [N-1:0] tempo,
  input  logic         cnt_zero,
  input  logic         cnt_half,
  output logic         cnt_clr,
  output logic         cnt_ld,
  output logic         cnt_ent,
  output logic         cnt_enp,
  output logic         cnt_sub,
  output logic [N-1:0] cnt_D,
  output logic         ativo,
  output logic         pausado,
  output logic         metade,
  output logic         fim,
  output logic [2:0]   estado_db
);

  localparam int PW = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK - 1);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    CONTA   = 3'd2,
    PAUSA   = 3'd3,
    FIM     = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [N-1:0]  d_q, d_d;
  logic          half_prev_q, half_prev_d;
  logic          metade_q, metade_d;
  logic          fim_q, fim_d;
  logic          presc_last;

  assign presc_last = (presc_q == PRESC_MAX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= OCIOSO;
      presc_q     <= '0;
      d_q         <= '0;
      half_prev_q <= 1'b0;
      metade_q    <= 1'b0;
      fim_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      d_q         <= d_d;
      half_prev_q <= half_prev_d;
      metade_q    <= metade_d;
      fim_q       <= fim_d;
    end
  end

  // fim_d marks every transition into FIM, including FIM re-entered from FIM by a zero start value.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    d_d     = d_q;
    fim_d   = 1'b0;
    unique case (state_q)
      OCIOSO: begin
        if (iniciar) begin
          if (tempo != '0) begin
            d_d     = tempo;
            state_d = CARREGA;
          end else begin
            state_d = FIM;
            fim_d   = 1'b1;
          end
        end
      end
      CARREGA: begin
        presc_d = '0;
        state_d = CONTA;
      end
      CONTA: begin
        presc_d = presc_last ? '0 : presc_q + PW'(1);
        if (cnt_zero) begin
          state_d = FIM;
          fim_d   = 1'b1;
        end else if (pausar) begin
          state_d = PAUSA;
        end
      end
      PAUSA: begin
        if (pausar) state_d = CONTA;
      end
      FIM: begin
        if (iniciar) begin
          d_d = tempo;
          if (tempo != '0) begin
            state_d = CARREGA;
          end else begin
            state_d = FIM;
            fim_d   = 1'b1;
          end
        end
      end
      default: state_d = OCIOSO;
    endcase
    if (cancelar && state_q != OCIOSO) begin
      state_d = OCIOSO;
      fim_d   = 1'b0;
    end
  end

  // The half-flag edge detector holds its history in PAUSA so resuming never fakes a rising edge.
  always_comb begin
    half_prev_d = (state_q == PAUSA) ? half_prev_q : cnt_half;
    metade_d    = (state_q == CONTA) && cnt_half && !half_prev_q;
  end

  always_comb begin
    cnt_clr   = (state_q != OCIOSO);
    cnt_ld    = (state_q != CARREGA);
    cnt_ent   = (state_q == CONTA);
    cnt_enp   = (state_q == CONTA) && presc_last && !cnt_zero;
    cnt_sub   = 1'b1;
    cnt_D     = d_q;
    ativo     = (state_q == CONTA) || (state_q == PAUSA);
    pausado   = (state_q == PAUSA);
    metade    = metade_q;
    fim       = fim_q;
    estado_db = state_q;
  end

endmodule

// File: tb/tb_controle_temporizador.sv
// Bench for controle_temporizador with a behavioural down-counter standing in for contador_163_n;
// expected fim/metade cycles go into scoreboards when a start is issued.
module tb_controle_temporizador;

  localparam int N    = 6;
  localparam int TICK = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         iniciar, pausar, cancelar;
  logic [N-1:0] tempo;
  logic         cnt_zero, cnt_half;
  logic         cnt_clr, cnt_ld, cnt_ent, cnt_enp, cnt_sub;
  logic [N-1:0] cnt_D;
  logic         ativo, pausado, metade, fim;
  logic [2:0]   estado_db;

  logic [N-1:0] q = '0;
  int           cyc = 0;
  int           vectors = 0;
  int           miscompares = 0;
  int           fim_exp[$];
  int           metade_exp[$];
  logic [N-1:0] q_frozen;

  controle_temporizador #(.N(N), .TICK(TICK)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .pausar(pausar), .cancelar(cancelar),
    .tempo(tempo), .cnt_zero(cnt_zero), .cnt_half(cnt_half), .cnt_clr(cnt_clr), .cnt_ld(cnt_ld),
    .cnt_ent(cnt_ent), .cnt_enp(cnt_enp), .cnt_sub(cnt_sub), .cnt_D(cnt_D), .ativo(ativo),
    .pausado(pausado), .metade(metade), .fim(fim), .estado_db(estado_db)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural counter: synchronous active-low clear and load, count when ent and enp.
  always_ff @(posedge clock) begin
    if (!cnt_clr)                q <= '0;
    else if (!cnt_ld)            q <= cnt_D;
    else if (cnt_ent && cnt_enp) q <= cnt_sub ? q - 6'd1 : q + 6'd1;
  end

  assign cnt_zero = (q == '0);
  assign cnt_half = (q == (cnt_D >> 1));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (fim === 1'b1) begin
      if (fim_exp.size() == 0) checkOutput("fim_spurious", fim, 0);
      else checkOutput("fim_cycle", cyc, fim_exp.pop_front());
    end
    if (metade === 1'b1) begin
      if (metade_exp.size() == 0) checkOutput("metade_spurious", metade, 0);
      else checkOutput("metade_cycle", cyc, metade_exp.pop_front());
    end
  end

  task automatic applyStimulus(input logic ini, input logic [N-1:0] t, input logic psr, input logic cnc);
    iniciar  = ini;
    tempo    = t;
    pausar   = psr;
    cancelar = cnc;
    @(negedge clock);
    iniciar  = 1'b0;
    pausar   = 1'b0;
    cancelar = 1'b0;
  endtask

  task automatic start_timer(input logic [N-1:0] t, input int pause_cycles, input bit expect_end);
    int s;
    int h;
    s = cyc + 1;
    h = int'(t >> 1);
    if (expect_end) begin
      if (t == '0) begin
        fim_exp.push_back(s);
      end else begin
        if (h != 0) metade_exp.push_back(s + 2 + (int'(t) - h) * TICK + pause_cycles);
        fim_exp.push_back(s + 2 + int'(t) * TICK + pause_cycles);
      end
    end
    applyStimulus(1'b1, t, 1'b0, 1'b0);
  endtask

  task automatic wait_state(input logic [2:0] st, input int limit, input string tag);
    int n;
    n = 0;
    while (estado_db !== st && n < limit) begin
      @(negedge clock);
      n++;
    end
    checkOutput(tag, estado_db, st);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; iniciar = 1'b0; pausar = 1'b0; cancelar = 1'b0; tempo = '0;
    repeat (3) @(negedge clock);
    checkOutput("rst_clr", cnt_clr, 0);
    checkOutput("rst_ld", cnt_ld, 1);
    checkOutput("rst_ent_enp", {cnt_ent, cnt_enp}, 0);
    checkOutput("rst_sub", cnt_sub, 1);
    checkOutput("rst_flags", {ativo, pausado, metade, fim}, 0);
    checkOutput("rst_estado", estado_db, 0);
    checkOutput("rst_D", cnt_D, 0);
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] basic countdown, tempo=3");
    start_timer(6'd3, 0, 1'b1);
    checkOutput("carrega_state", estado_db, 1);
    checkOutput("carrega_ld", cnt_ld, 0);
    checkOutput("carrega_clr", cnt_clr, 1);
    @(negedge clock);
    checkOutput("conta_state", estado_db, 2);
    checkOutput("conta_loaded_q", q, 3);
    checkOutput("conta_ativo", ativo, 1);
    for (int i = 0; i < 8; i++) begin
      checkOutput("enp_phase", cnt_enp, (i % 4 == 3));
      @(negedge clock);
    end
    wait_state(3'd4, 40, "t1_reach_fim");
    checkOutput("fim_q_zero", q, 0);
    @(negedge clock);
    checkOutput("fim_one_shot", fim, 0);
    checkOutput("fim_holds_state", estado_db, 4);
    checkOutput("fim_holds_q", q, 0);

    $display("[TB] halfway pulse, tempo=8");
    start_timer(6'd8, 0, 1'b1);
    wait_state(3'd4, 60, "t2_reach_fim");
    @(negedge clock);

    $display("[TB] pause and resume, tempo=3");
    start_timer(6'd3, 22, 1'b1);
    @(negedge clock);
    repeat (4) @(negedge clock);
    applyStimulus(1'b0, 6'd3, 1'b1, 1'b0);
    checkOutput("pausa_state", estado_db, 3);
    checkOutput("pausa_pausado", pausado, 1);
    q_frozen = q;
    for (int i = 0; i < 21; i++) begin
      @(negedge clock);
      checkOutput("pausa_q_frozen", q, q_frozen);
      checkOutput("pausa_no_enp", {cnt_ent, cnt_enp}, 0);
    end
    applyStimulus(1'b0, 6'd3, 1'b1, 1'b0);
    checkOutput("resume_state", estado_db, 2);
    wait_state(3'd4, 60, "t3_reach_fim");
    @(negedge clock);

    $display("[TB] cancel during count, tempo=5");
    start_timer(6'd5, 0, 1'b0);
    repeat (6) @(negedge clock);
    applyStimulus(1'b0, 6'd5, 1'b0, 1'b1);
    checkOutput("cancel_state", estado_db, 0);
    checkOutput("cancel_clr", cnt_clr, 0);
    checkOutput("cancel_q_before_clear", q, 4);
    @(negedge clock);
    checkOutput("cancel_q_cleared", q, 0);

    $display("[TB] zero start value from idle and from fim");
    start_timer(6'd0, 0, 1'b1);
    checkOutput("zero_from_idle", estado_db, 4);
    @(negedge clock);
    start_timer(6'd0, 0, 1'b1);
    checkOutput("zero_from_fim", estado_db, 4);
    @(negedge clock);

    $display("[TB] pausar coincident with counter zero, tempo=2");
    start_timer(6'd2, 0, 1'b1);
    begin
      int n;
      n = 0;
      while (!(q == '0 && estado_db == 3'd2) && n < 30) begin
        @(negedge clock);
        n++;
      end
      checkOutput("zero_reached_in_conta", {estado_db, q}, {3'd2, 6'd0});
    end
    applyStimulus(1'b0, 6'd2, 1'b1, 1'b0);
    checkOutput("zero_beats_pausar", estado_db, 4);
    @(negedge clock);

    $display("[TB] iniciar ignored while counting, tempo=3");
    start_timer(6'd3, 0, 1'b1);
    repeat (3) @(negedge clock);
    applyStimulus(1'b1, 6'd9, 1'b0, 1'b0);
    checkOutput("ignore_ini_D", cnt_D, 3);
    checkOutput("ignore_ini_state", estado_db, 2);
    wait_state(3'd4, 40, "t5_reach_fim");
    @(negedge clock);

    $display("[TB] async reset mid-count, tempo=4");
    start_timer(6'd4, 0, 1'b0);
    repeat (3) @(negedge clock);
    checkOutput("pre_reset_q", q, 4);
    reset = 1'b1;
    #1;
    checkOutput("async_estado", estado_db, 0);
    checkOutput("async_clr_ld", {cnt_clr, cnt_ld}, 2'b01);
    checkOutput("async_ent_enp", {cnt_ent, cnt_enp}, 0);
    checkOutput("async_flags", {ativo, pausado, metade, fim}, 0);
    checkOutput("async_D", cnt_D, 0);
    @(negedge clock);
    checkOutput("async_q_cleared", q, 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    checkOutput("fim_queue_drained", fim_exp.size(), 0);
    checkOutput("metade_queue_drained", metade_exp.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
